pdm_tx_modulator: RTL and testbench

- PDM audio transmitter: accepts signed PCM samples over an AXI4-Stream slave and emits a 1-bit pulse-density bitstream plus bit clock to an external PDM amplifier/filter.
- Output-side counterpart of the microphone PDM clock/capture path.
- Sits between the synth voice/mixer stream and the board audio-out pins.
- First-order error-feedback sigma-delta with a one-entry sample buffer and an OSR-paced sample fetch.

---
 rtl/pdm_tx_modulator_pkg.sv | 18 +
 rtl/pdm_tx_modulator_if.sv | 13 +
 rtl/pdm_tx_modulator_sd1_core.sv | 33 +++
 rtl/pdm_tx_modulator.sv | 99 +++++++++
 tb/tb_pdm_tx_modulator.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/pdm_tx_modulator_pkg.sv
// Shared constants, divider helpers and sample type for the PDM transmitter.
package pdm_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_OSR        = 64;

  typedef logic signed [DEFAULT_DATA_WIDTH-1:0] pcm_sample_t;

  function automatic int clk_divider(input int in_freq, input int out_freq);
    return in_freq / out_freq;
  endfunction

  // One pdm_clk phase lasts this many system clocks; the period is twice this.
  function automatic int half_divider(input int in_freq, input int out_freq);
    return clk_divider(in_freq, out_freq) / 2;
  endfunction

endpackage

// File: rtl/pdm_tx_modulator_if.sv
// AXI4-Stream sample channel feeding the PDM transmitter.
interface pdm_tx_modulator_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/pdm_tx_modulator_sd1_core.sv
// First-order error-feedback sigma-delta: offset-binary sample accumulated, carry is the PDM bit.
module sd1_core #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  step,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] sample,
  output logic                  pdm_bit
);

  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] u;
  logic [DATA_WIDTH:0]   sum;

  // NOTE: combinational paths use blocking '=' with every output assigned first; state uses '<='.
  always_comb begin
    u   = {~sample[DATA_WIDTH-1], sample[DATA_WIDTH-2:0]};
    sum = {1'b0, acc} + {1'b0, u};
  end

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      acc     <= '0;
      pdm_bit <= 1'b0;
    end else if (step) begin
      pdm_bit <= sum[DATA_WIDTH];
      acc     <= sum[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/pdm_tx_modulator.sv
// PDM audio transmitter: AXI4-Stream PCM in, pdm_clk/pdm_data/pdm_sd out.
module pdm_tx_modulator
  import pdm_pkg::*;
#(
  parameter int INPUT_FREQ  = 100000000,
  parameter int OUTPUT_FREQ = 2400000,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int OSR         = DEFAULT_OSR
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  pdm_tx_modulator_if.slave   s_axis,
  output logic                pdm_clk,
  output logic                pdm_data,
  output logic                pdm_sd,
  output logic                underrun
);

  localparam int HALF  = half_divider(INPUT_FREQ, OUTPUT_FREQ);
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BIT_W = $clog2(OSR);

  logic                  enable_q;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  buf_full;
  logic [DATA_WIDTH-1:0] buf_data;
  logic [DATA_WIDTH-1:0] active;
  logic                  div_wrap;
  logic                  bit_tick;
  logic                  load;
  logic                  load_from_full;
  logic                  accept;
  logic                  core_clear;

  assign div_wrap       = (div_cnt == DIV_W'(HALF - 1));
  // Bits advance on the wrap that drives pdm_clk low, so data is stable at the rising edge.
  assign bit_tick       = enable_q && div_wrap && pdm_clk;
  assign load           = bit_tick && (bit_cnt == BIT_W'(OSR - 1));
  assign load_from_full = load && buf_full;
  assign accept         = s_axis.tvalid && s_axis.tready;
  assign core_clear     = !enable_q;
  assign pdm_sd         = enable_q;

  always_ff @(posedge clk) begin
    if (!resetn) enable_q <= 1'b0;
    else         enable_q <= enable;
  end

  always_ff @(posedge clk) begin
    if (!resetn || !enable_q) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      pdm_clk <= 1'b0;
    end else begin
      if (div_wrap) begin
        div_cnt <= '0;
        pdm_clk <= ~pdm_clk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (bit_tick) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // NOTE: the sample buffer is a single register, so it is cleared with the rest; a disabled
  // stream must restart from midscale with nothing stale queued.
  always_ff @(posedge clk) begin
    if (!resetn || !enable_q) begin
      buf_full      <= 1'b0;
      buf_data      <= '0;
      active        <= '0;
      s_axis.tready <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      underrun      <= load && !buf_full;
      // Looks at this cycle's accept so tready never overlaps a full buffer.
      s_axis.tready <= !buf_full && !load_from_full && !accept;
      if (load_from_full) begin
        active   <= buf_data;
        buf_full <= 1'b0;
      end else if (accept) begin
        buf_data <= s_axis.tdata;
        buf_full <= 1'b1;
      end
    end
  end

  sd1_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .clk     (clk),
    .resetn  (resetn),
    .step    (bit_tick),
    .clear   (core_clear),
    .sample  (active),
    .pdm_bit (pdm_data)
  );

endmodule

// File: tb/tb_pdm_tx_modulator.sv
// Directed bench for pdm_tx_modulator: timing, density per 64-bit block, pacing, underrun, enable, reset.
module tb_pdm_tx_modulator;
  import pdm_pkg::*;

  localparam int DW = DEFAULT_DATA_WIDTH;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic enable = 1'b0;
  logic pdm_clk, pdm_data, pdm_sd, underrun;

  pdm_tx_modulator_if #(.DATA_WIDTH(DW)) axis ();

  pdm_tx_modulator #(
    .INPUT_FREQ  (100000000),
    .OUTPUT_FREQ (2400000),
    .DATA_WIDTH  (DW),
    .OSR         (64)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .enable   (enable),
    .s_axis   (axis),
    .pdm_clk  (pdm_clk),
    .pdm_data (pdm_data),
    .pdm_sd   (pdm_sd),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int n_compared = 0;
  int n_failed   = 0;

  // Observation counters, sampled on the falling system-clock edge.
  logic       prev_clk = 1'b0;
  logic       prev_data = 1'b0;
  int         cur_high = 0, cur_low = 0, last_high = 0, last_low = 0;
  int         nbits = 0, blk_ones = 0, last_blk_ones = 0, blk_count = 0;
  int         bad_edges = 0, underrun_total = 0, xfer_total = 0;
  logic [7:0] hist = 8'h00;

  always @(negedge clk) begin
    prev_clk  <= pdm_clk;
    prev_data <= pdm_data;
    if (underrun) underrun_total <= underrun_total + 1;
    if (axis.tvalid && axis.tready) xfer_total <= xfer_total + 1;
    if ((pdm_data !== prev_data) && !(prev_clk && !pdm_clk)) bad_edges <= bad_edges + 1;
    if (pdm_clk) cur_high <= cur_high + 1;
    else         cur_low  <= cur_low + 1;
    if (pdm_clk && !prev_clk) begin
      last_low <= cur_low;
      cur_low  <= 0;
    end
    if (!pdm_clk && prev_clk) begin
      last_high <= cur_high;
      cur_high  <= 0;
    end
    if (!pdm_sd) begin
      nbits     <= 0;
      blk_ones  <= 0;
      blk_count <= 0;
    end else if (prev_clk && !pdm_clk) begin
      hist <= {hist[6:0], pdm_data};
      if (nbits == 63) begin
        nbits         <= 0;
        last_blk_ones <= blk_ones + int'(pdm_data);
        blk_ones      <= 0;
        blk_count     <= blk_count + 1;
      end else begin
        nbits    <= nbits + 1;
        blk_ones <= blk_ones + int'(pdm_data);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait for the monitor to close block 'target', then settle past the refill transfer.
  task automatic wait_blk(input int target);
    int n;
    n = 0;
    while (blk_count < target && n < 4000) begin
      tick(1);
      n++;
    end
    check($sformatf("block %0d reached", target), 32'(blk_count >= target), 32'd1);
    tick(10);
  endtask

  function automatic logic [31:0] outs();
    return {27'd0, pdm_clk, pdm_data, pdm_sd, axis.tready, underrun};
  endfunction

  initial begin
    logic [31:0] any_high;
    logic        found;
    pcm_sample_t s_mid, s_max, s_min, s_quarter;
    s_mid     = 16'sh0000;
    s_max     = 16'sh7FFF;
    s_min     = 16'sh8000;
    s_quarter = 16'sh4000;

    axis.tdata  = s_mid;
    axis.tvalid = 1'b0;
    tick(5);
    check("outputs in reset", outs(), 32'd0);

    resetn   = 1'b1;
    any_high = '0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      any_high = any_high | outs();
    end
    check("idle with enable low", any_high, 32'd0);

    // Enable with midscale streamed continuously.
    enable      = 1'b1;
    axis.tvalid = 1'b1;
    tick(1);
    check("pdm_sd one cycle after enable", 32'(pdm_sd), 32'd1);
    check("tready low on enable_q edge", 32'(axis.tready), 32'd0);
    tick(19);
    check("pdm_clk low before HALF", 32'(pdm_clk), 32'd0);
    tick(1);
    check("first pdm_clk rise at HALF", 32'(pdm_clk), 32'd1);
    check("first transfer taken", 32'(xfer_total), 32'd1);
    check("tready low with buffer full", 32'(axis.tready), 32'd0);

    wait_blk(1);
    check("pdm_clk high phase", 32'(last_high), 32'd20);
    check("pdm_clk low phase", 32'(last_low), 32'd20);
    check("midscale ones per block", 32'(last_blk_ones), 32'd32);
    check("midscale 0101 pattern", 32'(hist), 32'h55);
    check("one refill per block (1)", 32'(xfer_total), 32'd2);
    check("tready low after refill", 32'(axis.tready), 32'd0);
    check("no underrun while fed", 32'(underrun_total), 32'd0);
    axis.tdata = s_max;

    wait_blk(2);
    check("one refill per block (2)", 32'(xfer_total), 32'd3);
    axis.tdata = s_min;

    wait_blk(3);
    check("one refill per block (3)", 32'(xfer_total), 32'd4);
    axis.tdata = s_quarter;

    wait_blk(4);
    check("0x7FFF ones per block", 32'(last_blk_ones), 32'd63);
    check("one refill per block (4)", 32'(xfer_total), 32'd5);
    axis.tvalid = 1'b0;

    wait_blk(5);
    check("0x8000 ones per block", 32'(last_blk_ones), 32'd0);
    check("no underrun with buffered sample", 32'(underrun_total), 32'd0);

    wait_blk(6);
    check("0x4000 ones per block", 32'(last_blk_ones), 32'd48);
    check("first underrun pulse", 32'(underrun_total), 32'd1);
    check("tready high with buffer empty", 32'(axis.tready), 32'd1);

    wait_blk(7);
    check("repeated sample density (1)", 32'(last_blk_ones), 32'd48);
    check("second underrun pulse", 32'(underrun_total), 32'd2);

    wait_blk(8);
    check("repeated sample density (2)", 32'(last_blk_ones), 32'd48);
    check("third underrun pulse", 32'(underrun_total), 32'd3);
    axis.tvalid = 1'b1;

    wait_blk(9);
    check("density after resume", 32'(last_blk_ones), 32'd48);
    check("underrun stops after resume", 32'(underrun_total), 32'd3);
    check("transfers after resume", 32'(xfer_total), 32'd7);
    check("buffer full before disable", 32'(axis.tready), 32'd0);
    check("data only moves on falling pdm_clk", 32'(bad_edges), 32'd0);

    // Drop enable mid-bit while both outputs are high.
    tick(400);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (pdm_clk && pdm_data) found = 1'b1;
      else tick(1);
    end
    check("found clk and data high", 32'(found), 32'd1);
    enable = 1'b0;
    tick(1);
    check("pdm_sd drops with enable_q", 32'(pdm_sd), 32'd0);
    tick(1);
    check("outputs cleared after disable", {29'd0, pdm_clk, pdm_data, axis.tready}, 32'd0);
    tick(50);
    check("quiet while disabled", outs(), 32'd0);
    check("no underrun while disabled", 32'(underrun_total), 32'd3);
    check("clean edges through disable", 32'(bad_edges), 32'd0);

    // Re-enable with no sample offered: fresh accumulator, empty buffer, midscale active.
    axis.tvalid = 1'b0;
    axis.tdata  = s_quarter;
    enable      = 1'b1;
    wait_blk(1);
    check("re-enable acc from zero", 32'(hist), 32'h55);
    check("re-enable active midscale", 32'(last_blk_ones), 32'd32);
    check("re-enable first load underruns", 32'(underrun_total), 32'd4);

    // Reset mid-operation overrides enable.
    resetn = 1'b0;
    tick(1);
    check("outputs after mid-run reset", outs(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
